vga_timing_gen: RTL and testbench

Parametrised video timing generator that succeeds the fixed 640x480 sync block. Divides the system clock into a pixel-rate enable and runs horizontal/vertical counters over user-supplied porch, sync and active widths, with selectable sync polarity. Provides hsync/vsync, video_on, pixel coordinates, and line/frame strobes. Sits between the board clock and the pixel generator/RAM reader in the display path.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_pixel_tick.sv | 41 ++++
 rtl/vga_timing_gen.sv | 145 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the video timing generator: 640x480@60 defaults,
// sync polarity encodings and the frame total helper.
package vga_timing_pkg;

    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam int unsigned DEF_CNT_W    = 10;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // Total period (line or frame) from its four segments
    function automatic int unsigned timing_total(input int unsigned active,
                                                 input int unsigned front,
                                                 input int unsigned sync,
                                                 input int unsigned back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate enable: divides clk by CLK_DIV, holding the divider while
// enable is low. pixel_tick is suppressed during reset.
module vga_pixel_tick
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic pixel_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             at_max;

    // Next divider value: wrap at CLK_DIV-1, hold when disabled
    always_comb begin
        at_max = (div_q == DIV_MAX);
        div_d  = div_q;
        if (enable) begin
            div_d = at_max ? '0 : div_q + DIV_W'(1);
        end
    end

    // Divider register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pixel_tick = reset & enable & at_max;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: pixel-rate counters, registered
// hsync/vsync, active-area flag, pixel coordinates and line/frame strobes.
// Define VGA_TIMING_ALIGN_EN to register pixelx/pixely/video_on so they
// share the one-clock latency of the sync outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter bit          HSYNC_POL = SYNC_ACTIVE_LOW,
    parameter bit          VSYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixelx,
    output logic [CNT_W-1:0] pixely,
    output logic             pixel_tick,
    output logic             line_end,
    output logic             frame_end
);

    localparam int unsigned H_TOT = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOT = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS        = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS        = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [CNT_W-1:0] hcount_q;
    logic [CNT_W-1:0] hcount_d;
    logic [CNT_W-1:0] vcount_q;
    logic [CNT_W-1:0] vcount_d;
    logic             hsync_q;
    logic             hsync_d;
    logic             vsync_q;
    logic             vsync_d;
    logic             h_last;
    logic             v_last;
    logic             video_on_c;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pixel_tick (pixel_tick)
    );

    // Counter advance: h wraps at end of line, v steps on h wrap
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        h_last   = (hcount_q == H_LAST);
        v_last   = (vcount_q == V_LAST);
        if (pixel_tick) begin
            hcount_d = h_last ? '0 : hcount_q + CNT_W'(1);
            if (h_last) begin
                vcount_d = v_last ? '0 : vcount_q + CNT_W'(1);
            end
        end
    end

    // Sync window decode from the current counters
    always_comb begin
        hsync_d = ((hcount_q >= H_SYNC_START) && (hcount_q <= H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = ((vcount_q >= V_SYNC_START) && (vcount_q <= V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
        video_on_c = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    end

    // Counter and sync registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign line_end  = pixel_tick & h_last;
    assign frame_end = line_end & v_last;

`ifdef VGA_TIMING_ALIGN_EN
    logic [CNT_W-1:0] pixelx_q;
    logic [CNT_W-1:0] pixelx_d;
    logic [CNT_W-1:0] pixely_q;
    logic [CNT_W-1:0] pixely_d;
    logic             video_on_q;
    logic             video_on_d;

    // Coordinates and active flag delayed to line up with the syncs
    always_comb begin
        pixelx_d   = hcount_q;
        pixely_d   = vcount_q;
        video_on_d = video_on_c;
    end

    // Aligned coordinate registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixelx_q   <= '0;
            pixely_q   <= '0;
            video_on_q <= 1'b0;
        end else begin
            pixelx_q   <= pixelx_d;
            pixely_q   <= pixely_d;
            video_on_q <= video_on_d;
        end
    end

    assign pixelx   = pixelx_q;
    assign pixely   = pixely_q;
    assign video_on = video_on_q;
`else
    assign pixelx   = hcount_q;
    assign pixely   = vcount_q;
    assign video_on = video_on_c;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 line timing, a reduced
// frame (CLK_DIV=2, 32x20), its active-high polarity twin, and a CLK_DIV=1
// 14x7 raster. Expected values come from closed-form position formulas.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_ALIGN_EN
    localparam int LAT    = 1;
    localparam bit RST_VO = 1'b0;
`else
    localparam int LAT    = 0;
    localparam bit RST_VO = 1'b1;
`endif

    logic clk;
    int   n_tests;
    int   n_fail;

    logic d_rst, d_en, d_hs, d_vs, d_vo, d_pt, d_le, d_fe;
    logic [9:0] d_px, d_py;
    logic m_rst, m_en, m_hs, m_vs, m_vo, m_pt, m_le, m_fe;
    logic [5:0] m_px, m_py;
    logic p_rst, p_en, p_hs, p_vs, p_vo, p_pt, p_le, p_fe;
    logic [5:0] p_px, p_py;
    logic s_rst, s_en, s_hs, s_vs, s_vo, s_pt, s_le, s_fe;
    logic [3:0] s_px, s_py;

    vga_timing_gen u_def (
        .clk(clk), .reset(d_rst), .enable(d_en), .hsync(d_hs), .vsync(d_vs),
        .video_on(d_vo), .pixelx(d_px), .pixely(d_py), .pixel_tick(d_pt),
        .line_end(d_le), .frame_end(d_fe)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_ACTIVE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(3),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(6)
    ) u_mid (
        .clk(clk), .reset(m_rst), .enable(m_en), .hsync(m_hs), .vsync(m_vs),
        .video_on(m_vo), .pixelx(m_px), .pixely(m_py), .pixel_tick(m_pt),
        .line_end(m_le), .frame_end(m_fe)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_ACTIVE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(6)
    ) u_pol (
        .clk(clk), .reset(p_rst), .enable(p_en), .hsync(p_hs), .vsync(p_vs),
        .video_on(p_vo), .pixelx(p_px), .pixely(p_py), .pixel_tick(p_pt),
        .line_end(p_le), .frame_end(p_fe)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CNT_W(4)
    ) u_small (
        .clk(clk), .reset(s_rst), .enable(s_en), .hsync(s_hs), .vsync(s_vs),
        .video_on(s_vo), .pixelx(s_px), .pixely(s_py), .pixel_tick(s_pt),
        .line_end(s_le), .frame_end(s_fe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not hold
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Horizontal / vertical position after k clocks from reset release
    function automatic int pos_h(input int k, input int div, input int htot);
        return (k / div) % htot;
    endfunction

    function automatic int pos_v(input int k, input int div, input int htot, input int vtot);
        return (k / div / htot) % vtot;
    endfunction

    initial begin
        int  bad, ticks, first_tick, le_cnt, le_x, le_k, hs_low, hs_first, vs_low;
        int  px_a, px_b, fe_cnt, fe_first, fe_second, vs_first;
        int  ph_high, ph_first, pv_high, last_le, last_fe, found, wrap_x, wrap_y;
        bit  exp_vo;

        n_tests = 0;
        n_fail  = 0;
        d_rst = 1'b0; m_rst = 1'b0; p_rst = 1'b0; s_rst = 1'b0;
        d_en  = 1'b1; m_en  = 1'b1; p_en  = 1'b1; s_en  = 1'b1;

        repeat (3) @(negedge clk);
        check("def_rst_hsync", 32'(d_hs), 32'd1);
        check("def_rst_vsync", 32'(d_vs), 32'd1);
        check("def_rst_tick", 32'(d_pt), 32'd0);
        check("def_rst_strobes", 32'({d_le, d_fe}), 32'd0);
        check("def_rst_px", 32'(d_px), 32'd0);
        check("def_rst_py", 32'(d_py), 32'd0);
        check("def_rst_video_on", 32'(d_vo), 32'(RST_VO));
        check("pol_rst_hsync", 32'(p_hs), 32'd0);
        check("pol_rst_vsync", 32'(p_vs), 32'd0);
        check("small_rst_tick", 32'(s_pt), 32'd0);

        // Default timing: first ticks and one full line
        d_rst = 1'b1;
        bad = 0; ticks = 0; first_tick = -1; le_cnt = 0; le_x = -1; le_k = -1;
        hs_low = 0; hs_first = -1; vs_low = 0; px_a = -1; px_b = -1;
        for (int k = 1; k <= 3210; k++) begin
            @(negedge clk);
            if (d_pt) begin
                ticks++;
                if (first_tick < 0) first_tick = k;
            end
            if (d_le) begin
                le_cnt++;
                le_x = 32'(d_px);
                le_k = k;
            end
            if (!d_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = k;
            end
            if (!d_vs) vs_low++;
            if (k == 3 + LAT) px_a = 32'(d_px);
            if (k == 4 + LAT) px_b = 32'(d_px);
            exp_vo = (pos_h(k - LAT, 4, 800) < 640) && (pos_v(k - LAT, 4, 800, 525) < 480);
            if (32'(d_px) != pos_h(k - LAT, 4, 800)) bad++;
            if (32'(d_py) != pos_v(k - LAT, 4, 800, 525)) bad++;
            if (d_vo != exp_vo) bad++;
            if (d_pt != ((k % 4) == 3)) bad++;
        end
        check("def_first_tick", first_tick, 3);
        check("def_px_before_tick", px_a, 0);
        check("def_px_after_tick", px_b, 1);
        check("def_tick_count", ticks, 802);
        check("def_line_end_count", le_cnt, 1);
        check("def_line_end_x", le_x, 799);
        check("def_line_end_clk", le_k, 3199);
        check("def_hsync_low_clks", hs_low, 384);
        check("def_hsync_first_low", hs_first, 2625);
        check("def_vsync_low_clks", vs_low, 0);
        check("def_position_trace", bad, 0);
        d_rst = 1'b0;

        // Reduced frame, both polarities side by side
        m_rst = 1'b1;
        p_rst = 1'b1;
        bad = 0; fe_cnt = 0; fe_first = -1; fe_second = -1; le_cnt = 0;
        vs_low = 0; vs_first = -1; hs_low = 0; ph_high = 0; ph_first = -1; pv_high = 0;
        wrap_x = -1; wrap_y = -1;
        for (int k = 1; k <= 2600; k++) begin
            @(negedge clk);
            if (m_fe) begin
                fe_cnt++;
                if (fe_first < 0) fe_first = k;
                else if (fe_second < 0) fe_second = k;
            end
            if (m_le) le_cnt++;
            if (!m_vs) begin
                vs_low++;
                if (vs_first < 0) vs_first = k;
            end
            if (!m_hs) hs_low++;
            if (p_hs) begin
                ph_high++;
                if (ph_first < 0) ph_first = k;
            end
            if (p_vs) pv_high++;
            if (k == 1281) begin
                wrap_x = 32'(m_px);
                wrap_y = 32'(m_py);
            end
            exp_vo = (pos_h(k - LAT, 2, 32) < 16) && (pos_v(k - LAT, 2, 32, 20) < 12);
            if (32'(m_px) != pos_h(k - LAT, 2, 32)) bad++;
            if (32'(m_py) != pos_v(k - LAT, 2, 32, 20)) bad++;
            if (m_vo != exp_vo) bad++;
            if (m_pt != ((k % 2) == 1)) bad++;
        end
        check("mid_frame_end_count", fe_cnt, 2);
        check("mid_frame_end_first", fe_first, 1279);
        check("mid_frame_length", fe_second - fe_first, 1280);
        check("mid_line_end_count", le_cnt, 40);
        check("mid_vsync_low_clks", vs_low, 256);
        check("mid_vsync_first_low", vs_first, 961);
        check("mid_hsync_low_clks", hs_low, 640);
        check("mid_wrap_x", wrap_x, 0);
        check("mid_wrap_y", wrap_y, 0);
        check("mid_position_trace", bad, 0);
        check("pol_hsync_high_clks", ph_high, 640);
        check("pol_hsync_first_high", ph_first, 41);
        check("pol_vsync_high_clks", pv_high, 256);

        // CLK_DIV=1 small raster: strobe spacing
        s_rst = 1'b1;
        ticks = 0; le_cnt = 0; fe_cnt = 0; fe_first = -1; last_le = -1; last_fe = -1; bad = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (s_pt) ticks++;
            if (s_le) begin
                le_cnt++;
                if (last_le >= 0 && (k - last_le) != 14) bad++;
                last_le = k;
            end
            if (s_fe) begin
                fe_cnt++;
                if (fe_first < 0) fe_first = k;
                if (last_fe >= 0 && (k - last_fe) != 98) bad++;
                last_fe = k;
            end
        end
        check("small_tick_count", ticks, 300);
        check("small_line_end_count", le_cnt, 21);
        check("small_frame_end_count", fe_cnt, 3);
        check("small_frame_end_first", fe_first, 97);
        check("small_strobe_spacing", bad, 0);

        // Mid-frame enable drop at (10,10), then reset at (24,12)
        m_rst = 1'b0;
        @(negedge clk);
        m_rst = 1'b1;
        repeat (660) @(negedge clk);
        m_en = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_px != 6'd10 || m_py != 6'd10) bad++;
            if (m_pt || m_le || !m_hs || !m_vs || !m_vo) bad++;
        end
        check("mid_freeze_hold", bad, 0);
        m_en = 1'b1;
        @(negedge clk);
        check("mid_resume_tick", 32'(m_pt), 32'd1);
        repeat (2) @(negedge clk);
        check("mid_resume_x", 32'(m_px), 32'd11);

        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            @(negedge clk);
            if (m_px == 6'd24 && m_py == 6'd12) found = 1;
        end
        check("mid_seek_24_12", found, 1);
        check("mid_pre_reset_hsync", 32'(m_hs), 32'd0);
        m_rst = 1'b0;
        #1;
        check("mid_async_rst_px", 32'(m_px), 32'd0);
        check("mid_async_rst_py", 32'(m_py), 32'd0);
        check("mid_async_rst_hsync", 32'(m_hs), 32'd1);
        check("mid_async_rst_vsync", 32'(m_vs), 32'd1);
        check("mid_async_rst_strobes", 32'({m_pt, m_le, m_fe}), 32'd0);
        check("mid_async_rst_video_on", 32'(m_vo), 32'(RST_VO));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
